reorder_buffer: RTL and testbench

In-order retirement buffer that consumes the decoded instruction stream from the ID/IDROB pipeline register and is the next stage after it.
- Allocation: one entry per accepted instruction; the entry index is returned as the rsid used by the decoder's `*_is_rsid` operand tagging.
- Completion and operand lookup: results are written back by rsid, and the buffer answers two operand-lookup ports for rsid-tagged operands.
- Retirement: at most one completed instruction per cycle, strictly in program order, to the regfile/CP0 commit logic.

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Entries are allocated at tail in program order, completed
// out of order by rsid writeback, and retired one per cycle from head once done.
module reorder_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned EXC_TYPE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  // allocation from IDROB
  input  logic                  alloc_en,
  input  logic                  alloc_reg_write_en,
  input  logic [4:0]            alloc_reg_write_addr,
  input  logic [EXC_TYPE_W-1:0] alloc_exception_type,
  input  logic [31:0]           alloc_pc,
  output logic [DEPTH_LOG2-1:0] alloc_rsid,
  output logic                  full,
  output logic                  empty,
  // result writeback
  input  logic                  wb_en,
  input  logic [DEPTH_LOG2-1:0] wb_rsid,
  input  logic [31:0]           wb_data,
  // operand lookup
  input  logic [DEPTH_LOG2-1:0] read_rsid_1,
  input  logic [DEPTH_LOG2-1:0] read_rsid_2,
  output logic                  read_ready_1,
  output logic                  read_ready_2,
  output logic [31:0]           read_data_1,
  output logic [31:0]           read_data_2,
  // retirement
  input  logic                  commit_stall,
  output logic                  commit_en,
  output logic                  commit_reg_write_en,
  output logic [4:0]            commit_reg_write_addr,
  output logic [31:0]           commit_data,
  output logic [EXC_TYPE_W-1:0] commit_exception_type,
  output logic [31:0]           commit_pc
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = Depth[DEPTH_LOG2:0];

  logic [Depth-1:0]      valid_q, done_q;
  logic                  rw_en_q   [Depth];
  logic [4:0]            rw_addr_q [Depth];
  logic [EXC_TYPE_W-1:0] exc_q     [Depth];
  logic [31:0]           pc_q      [Depth];
  logic [31:0]           data_q    [Depth];

  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  alloc_fire, wb_fire;

  assign full       = (count_q == FullCount);
  assign empty      = (count_q == '0);
  assign alloc_rsid = tail_q;
  // Full blocks allocation even if head retires this cycle; the slot frees next cycle.
  assign alloc_fire = alloc_en & ~full & ~flush;
  assign wb_fire    = wb_en & valid_q[wb_rsid] & ~flush;
  assign commit_en  = valid_q[head_q] & done_q[head_q] & ~commit_stall & ~flush;

  // Next-state for head/tail pointers and occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) tail_d = tail_q + 1'b1;
      if (commit_en)  head_d = head_q + 1'b1;
      if (alloc_fire && !commit_en)      count_d = count_q + 1'b1;
      else if (!alloc_fire && commit_en) count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Per-entry valid/done flags; flush and reset discard every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (wb_fire)   done_q[wb_rsid] <= 1'b1;
      if (commit_en) valid_q[head_q] <= 1'b0;
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        // A decode fault has no result to wait for.
        done_q[tail_q]  <= (alloc_exception_type != '0);
      end
    end
  end

  // Entry payload; only observed through valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rw_en_q[tail_q]   <= alloc_reg_write_en;
      rw_addr_q[tail_q] <= alloc_reg_write_addr;
      exc_q[tail_q]     <= alloc_exception_type;
      pc_q[tail_q]      <= alloc_pc;
      data_q[tail_q]    <= '0;
    end
    if (wb_fire) data_q[wb_rsid] <= wb_data;
  end

  // Operand lookup with same-cycle writeback bypass; not-ready reads return zero.
  always_comb begin
    read_ready_1 = 1'b0;
    read_data_1  = '0;
    if (wb_en && wb_rsid == read_rsid_1 && valid_q[read_rsid_1]) begin
      read_ready_1 = 1'b1;
      read_data_1  = wb_data;
    end else if (valid_q[read_rsid_1] && done_q[read_rsid_1]) begin
      read_ready_1 = 1'b1;
      read_data_1  = data_q[read_rsid_1];
    end
  end

  // Second operand lookup port, same behaviour as the first.
  always_comb begin
    read_ready_2 = 1'b0;
    read_data_2  = '0;
    if (wb_en && wb_rsid == read_rsid_2 && valid_q[read_rsid_2]) begin
      read_ready_2 = 1'b1;
      read_data_2  = wb_data;
    end else if (valid_q[read_rsid_2] && done_q[read_rsid_2]) begin
      read_ready_2 = 1'b1;
      read_data_2  = data_q[read_rsid_2];
    end
  end

  // Commit outputs mirror the head entry only while it retires.
  always_comb begin
    commit_reg_write_en   = 1'b0;
    commit_reg_write_addr = '0;
    commit_data           = '0;
    commit_exception_type = '0;
    commit_pc             = '0;
    if (commit_en) begin
      commit_reg_write_en   = rw_en_q[head_q];
      commit_reg_write_addr = rw_addr_q[head_q];
      commit_data           = data_q[head_q];
      commit_exception_type = exc_q[head_q];
      commit_pc             = pc_q[head_q];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order completion, fill/wrap,
// operand bypass, decode exceptions under stall, flush and asynchronous reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alloc_en, alloc_reg_write_en;
  logic [4:0]  alloc_reg_write_addr;
  logic [4:0]  alloc_exception_type;
  logic [31:0] alloc_pc;
  logic [3:0]  alloc_rsid;
  logic        full, empty;
  logic        wb_en;
  logic [3:0]  wb_rsid;
  logic [31:0] wb_data;
  logic [3:0]  read_rsid_1, read_rsid_2;
  logic        read_ready_1, read_ready_2;
  logic [31:0] read_data_1, read_data_2;
  logic        commit_stall, commit_en, commit_reg_write_en;
  logic [4:0]  commit_reg_write_addr;
  logic [31:0] commit_data;
  logic [4:0]  commit_exception_type;
  logic [31:0] commit_pc;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.DEPTH_LOG2(4), .EXC_TYPE_W(5)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .alloc_en              (alloc_en),
    .alloc_reg_write_en    (alloc_reg_write_en),
    .alloc_reg_write_addr  (alloc_reg_write_addr),
    .alloc_exception_type  (alloc_exception_type),
    .alloc_pc              (alloc_pc),
    .alloc_rsid            (alloc_rsid),
    .full                  (full),
    .empty                 (empty),
    .wb_en                 (wb_en),
    .wb_rsid               (wb_rsid),
    .wb_data               (wb_data),
    .read_rsid_1           (read_rsid_1),
    .read_rsid_2           (read_rsid_2),
    .read_ready_1          (read_ready_1),
    .read_ready_2          (read_ready_2),
    .read_data_1           (read_data_1),
    .read_data_2           (read_data_2),
    .commit_stall          (commit_stall),
    .commit_en             (commit_en),
    .commit_reg_write_en   (commit_reg_write_en),
    .commit_reg_write_addr (commit_reg_write_addr),
    .commit_data           (commit_data),
    .commit_exception_type (commit_exception_type),
    .commit_pc             (commit_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_en = 1'b0; alloc_reg_write_en = 1'b0;
    alloc_reg_write_addr = '0; alloc_exception_type = '0; alloc_pc = '0;
    wb_en = 1'b0; wb_rsid = '0; wb_data = '0; read_rsid_1 = '0; read_rsid_2 = '0;
    commit_stall = 1'b0;
    #3;
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_rsid", {28'd0, alloc_rsid}, 32'd0);
    chk("rst_commit", {31'd0, commit_en}, 32'd0);
    chk("rst_ready1", {31'd0, read_ready_1}, 32'd0);
    #9 rst = 1'b0;
    tick();

    // Single allocation, writeback, commit.
    alloc_en = 1'b1; alloc_pc = 32'hbfc00000; alloc_reg_write_en = 1'b1;
    alloc_reg_write_addr = 5'd8;
    #1;
    chk("t1_rsid", {28'd0, alloc_rsid}, 32'd0);
    tick();
    alloc_en = 1'b0;
    chk("t1_empty", {31'd0, empty}, 32'd0);
    wb_en = 1'b1; wb_rsid = 4'd0; wb_data = 32'h12345678;
    #1;
    chk("t1_no_commit_in_wb", {31'd0, commit_en}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("t1_commit", {31'd0, commit_en}, 32'd1);
    chk("t1_addr", {27'd0, commit_reg_write_addr}, 32'd8);
    chk("t1_wr", {31'd0, commit_reg_write_en}, 32'd1);
    chk("t1_data", commit_data, 32'h12345678);
    chk("t1_pc", commit_pc, 32'hbfc00000);
    tick();
    chk("t1_single_pulse", {31'd0, commit_en}, 32'd0);
    chk("t1_empty_after", {31'd0, empty}, 32'd1);

    // Out-of-order writeback, in-order commit.
    do_flush();
    alloc_en = 1'b1; alloc_reg_write_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc_pc = 32'h1000 + 32'(i) * 4; alloc_reg_write_addr = 5'(i + 1);
      #1;
      chk($sformatf("t2_rsid%0d", i), {28'd0, alloc_rsid}, 32'(i));
      tick();
    end
    alloc_en = 1'b0;
    wb_en = 1'b1; wb_rsid = 4'd2; wb_data = 32'h22;
    #1;
    chk("t2_wait_a", {31'd0, commit_en}, 32'd0);
    tick();
    wb_rsid = 4'd0; wb_data = 32'h0;
    #1;
    chk("t2_wait_b", {31'd0, commit_en}, 32'd0);
    tick();
    wb_rsid = 4'd1; wb_data = 32'h11;
    #1;
    chk("t2_c0_en", {31'd0, commit_en}, 32'd1);
    chk("t2_c0_pc", commit_pc, 32'h1000);
    chk("t2_c0_data", commit_data, 32'h0);
    tick();
    wb_en = 1'b0;
    chk("t2_c1_en", {31'd0, commit_en}, 32'd1);
    chk("t2_c1_pc", commit_pc, 32'h1004);
    chk("t2_c1_data", commit_data, 32'h11);
    tick();
    chk("t2_c2_en", {31'd0, commit_en}, 32'd1);
    chk("t2_c2_pc", commit_pc, 32'h1008);
    chk("t2_c2_data", commit_data, 32'h22);
    tick();
    chk("t2_done", {31'd0, commit_en}, 32'd0);
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // Fill all 16 entries, then wrap.
    do_flush();
    alloc_en = 1'b1; alloc_reg_write_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      alloc_pc = 32'(i) * 4;
      #1;
      chk($sformatf("t3_rsid%0d", i), {28'd0, alloc_rsid}, 32'(i));
      chk($sformatf("t3_notfull%0d", i), {31'd0, full}, 32'd0);
      tick();
    end
    alloc_pc = 32'h100;
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_tail_wrapped", {28'd0, alloc_rsid}, 32'd0);
    tick();
    chk("t3_still_full", {31'd0, full}, 32'd1);
    wb_en = 1'b1; wb_rsid = 4'd0; wb_data = 32'ha0;
    tick();
    wb_en = 1'b0;
    chk("t3_commit_while_full", {31'd0, commit_en}, 32'd1);
    chk("t3_commit_pc", commit_pc, 32'h0);
    chk("t3_full_at_commit", {31'd0, full}, 32'd1);
    tick();
    chk("t3_freed", {31'd0, full}, 32'd0);
    chk("t3_wrap_rsid", {28'd0, alloc_rsid}, 32'd0);
    tick();
    chk("t3_refull", {31'd0, full}, 32'd1);
    chk("t3_tail1", {28'd0, alloc_rsid}, 32'd1);
    alloc_en = 1'b0;
    do_flush();

    // Operand lookup with bypass.
    alloc_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    alloc_en = 1'b0;
    read_rsid_1 = 4'd3; read_rsid_2 = 4'd0;
    #1;
    chk("t4_pre_ready", {31'd0, read_ready_1}, 32'd0);
    chk("t4_pre_data", read_data_1, 32'd0);
    wb_en = 1'b1; wb_rsid = 4'd3; wb_data = 32'habcdef00;
    #1;
    chk("t4_byp_ready", {31'd0, read_ready_1}, 32'd1);
    chk("t4_byp_data", read_data_1, 32'habcdef00);
    chk("t4_other_ready", {31'd0, read_ready_2}, 32'd0);
    tick();
    wb_en = 1'b0; read_rsid_2 = 4'd3;
    #1;
    chk("t4_post_ready1", {31'd0, read_ready_1}, 32'd1);
    chk("t4_post_data1", read_data_1, 32'habcdef00);
    chk("t4_post_data2", read_data_2, 32'habcdef00);
    do_flush();

    // Decode exception held back by commit_stall.
    commit_stall = 1'b1;
    alloc_en = 1'b1; alloc_exception_type = 5'd1; alloc_pc = 32'h80000180;
    alloc_reg_write_en = 1'b1; alloc_reg_write_addr = 5'd5;
    tick();
    alloc_en = 1'b0; alloc_exception_type = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_stall%0d", i), {31'd0, commit_en}, 32'd0);
      if (i < 2) tick();
    end
    commit_stall = 1'b0;
    #1;
    chk("t5_commit", {31'd0, commit_en}, 32'd1);
    chk("t5_exc", {27'd0, commit_exception_type}, 32'd1);
    chk("t5_pc", commit_pc, 32'h80000180);
    chk("t5_data", commit_data, 32'd0);
    tick();
    chk("t5_empty", {31'd0, empty}, 32'd1);

    // Flush with 5 live entries while the head is eligible to commit.
    alloc_en = 1'b1; alloc_reg_write_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    alloc_en = 1'b0;
    wb_en = 1'b1; wb_rsid = 4'd1; wb_data = 32'h55;
    tick();
    wb_en = 1'b0;
    chk("t6_pending", {31'd0, commit_en}, 32'd1);
    flush = 1'b1;
    #1;
    chk("t6_flush_no_commit", {31'd0, commit_en}, 32'd0);
    tick();
    flush = 1'b0;
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_rsid0", {28'd0, alloc_rsid}, 32'd0);

    // Asynchronous reset mid-cycle with a commit pending.
    alloc_en = 1'b1;
    tick(); tick();
    alloc_en = 1'b0;
    wb_en = 1'b1; wb_rsid = 4'd0; wb_data = 32'h77;
    tick();
    wb_en = 1'b0; read_rsid_1 = 4'd0;
    chk("t7_pre_commit", {31'd0, commit_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_commit", {31'd0, commit_en}, 32'd0);
    chk("t7_cdata", commit_data, 32'd0);
    chk("t7_empty", {31'd0, empty}, 32'd1);
    chk("t7_rsid", {28'd0, alloc_rsid}, 32'd0);
    chk("t7_ready", {31'd0, read_ready_1}, 32'd0);
    #3 rst = 1'b0;
    tick();
    chk("t7_no_commit_a", {31'd0, commit_en}, 32'd0);
    tick();
    chk("t7_no_commit_b", {31'd0, commit_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
